// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains a byte FIFO through its rd/empty port, packs bytes
// little-endian into 32-bit words and offers each word on a valid/ready port
// with a byte count. Partial words leave on flush or after TIMEOUT idle cycles.
//
// Handshake: m_valid rises only in EMIT and stays high, with m_data/m_bytes
// frozen, until the cycle in which m_ready is also high; that cycle is the
// transfer and the packer returns to FILL on the following edge.
module fifo_word_packer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd,
    input  logic        flush,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [2:0]  m_bytes,
    output logic [1:0]  state_dbg
);

    // Idle counter only needs to reach TIMEOUT-1.
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        CAPT = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    byte_cnt;
    logic [2:0]    byte_cnt_next;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_next;
    logic [31:0]   word;
    logic [31:0]   word_next;

    logic has_bytes;
    logic flush_go;

    assign has_bytes = (byte_cnt != 3'd0);
    // Flush only matters when there is something to emit; it wins over a read.
    assign flush_go  = flush && has_bytes;

    // State and datapath registers; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL;
            byte_cnt <= 3'd0;
            idle_cnt <= '0;
            word     <= 32'd0;
        end else begin
            state    <= state_next;
            byte_cnt <= byte_cnt_next;
            idle_cnt <= idle_next;
            word     <= word_next;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_next    = state;
        byte_cnt_next = byte_cnt;
        idle_next     = idle_cnt;
        word_next     = word;
        case (state)
            FILL: begin
                if (flush_go) begin
                    state_next = EMIT;
                end else if (!fifo_empty) begin
                    state_next = CAPT;
                    idle_next  = '0;
                end else if (has_bytes && (TIMEOUT != 0)) begin
                    if (idle_cnt == IDLE_LAST) begin
                        state_next = EMIT;
                    end else begin
                        idle_next = idle_cnt + IW'(1);
                    end
                end else if (!has_bytes) begin
                    idle_next = '0;
                end
            end
            CAPT: begin
                // fifo_data is valid now, one cycle after the read strobe.
                word_next[{byte_cnt[1:0], 3'b000} +: 8] = fifo_data;
                byte_cnt_next = byte_cnt + 3'd1;
                state_next    = (byte_cnt == 3'd3) ? EMIT : FILL;
            end
            EMIT: begin
                if (m_ready) begin
                    word_next     = 32'd0;
                    byte_cnt_next = 3'd0;
                    idle_next     = '0;
                    state_next    = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Outputs decoded from registered state; read strobe is a single-cycle pulse
    // because every read is followed by a CAPT cycle.
    always_comb begin
        fifo_rd   = (state == FILL) && !fifo_empty && !flush_go;
        m_valid   = (state == EMIT);
        m_data    = (state == EMIT) ? word : 32'd0;
        m_bytes   = (state == EMIT) ? byte_cnt : 3'd0;
        state_dbg = state;
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: behavioural byte FIFOs feed two
// instances (TIMEOUT=16 and TIMEOUT=0); a negedge monitor scores every
// accepted word against an expected queue.
module tb_fifo_word_packer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        fifo_empty, fifo_rd, flush, m_valid, m_ready;
    logic [7:0]  fifo_data = 8'd0;
    logic [31:0] m_data;
    logic [2:0]  m_bytes;
    logic [1:0]  state_dbg;

    logic        fifo0_empty, fifo0_rd, flush0, m0_valid, m0_ready;
    logic [7:0]  fifo0_data = 8'd0;
    logic [31:0] m0_data;
    logic [2:0]  m0_bytes;
    logic [1:0]  state0_dbg;

    fifo_word_packer #(.TIMEOUT(16)) u_dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_bytes(m_bytes), .state_dbg(state_dbg)
    );

    fifo_word_packer #(.TIMEOUT(0)) u_dut0 (
        .clk(clk), .reset(reset), .fifo_empty(fifo0_empty), .fifo_data(fifo0_data),
        .fifo_rd(fifo0_rd), .flush(flush0), .m_valid(m0_valid), .m_ready(m0_ready),
        .m_data(m0_data), .m_bytes(m0_bytes), .state_dbg(state0_dbg)
    );

    // ---------------- FIFO models ----------------
    logic [7:0] fifo_q[$];
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    int         fifo_cnt = 0;

    always @(posedge clk) begin
        if (fifo_rd && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        if (wr_en) fifo_q.push_back(wr_data);
        fifo_cnt <= fifo_q.size();
    end
    assign fifo_empty = (fifo_cnt == 0);

    logic [7:0] fifo0_q[$];
    logic       wr0_en = 1'b0;
    logic [7:0] wr0_data = 8'd0;
    int         fifo0_cnt = 0;

    always @(posedge clk) begin
        if (fifo0_rd && fifo0_q.size() > 0) fifo0_data <= fifo0_q.pop_front();
        if (wr0_en) fifo0_q.push_back(wr0_data);
        fifo0_cnt <= fifo0_q.size();
    end
    assign fifo0_empty = (fifo0_cnt == 0);

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];   // {m_bytes, m_data}

    task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rd_total = 0;
    int   b2b = 0;
    int   last_rd_cyc = 0;
    int   valid_rise_cyc = 0;
    int   words = 0;
    int   hs_cyc[$];
    logic prev_rd = 1'b0;
    logic prev_valid = 1'b0;
    logic m0_seen = 1'b0;

    always @(negedge clk) begin
        if (fifo_rd) begin
            rd_total    <= rd_total + 1;
            last_rd_cyc <= cyc;
            if (prev_rd) b2b <= b2b + 1;
        end
        prev_rd <= fifo_rd;
        if (m_valid && !prev_valid) valid_rise_cyc <= cyc;
        prev_valid <= m_valid;
        if (m0_valid) m0_seen <= 1'b1;
        if (m_valid && m_ready) begin
            words <= words + 1;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) check_eq("extra_word", 35'(exp_q.size()), 35'd1);
            else check_eq("word", {m_bytes, m_data}, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic push0(input logic [7:0] b);
        wr0_en = 1'b1; wr0_data = b;
        step();
        wr0_en = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int target);
        int n = 0;
        while (words < target && n < 600) begin
            step();
            n++;
        end
        check_eq(tag, 35'(words), 35'(target));
    endtask

    task automatic wait_rd(input string tag, input int target);
        int n = 0;
        while (rd_total < target && n < 200) begin
            step();
            n++;
        end
        check_eq(tag, 35'(rd_total), 35'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int base_rd, base_b2b, base_w;

    initial begin
        reset = 1'b1; flush = 1'b0; m_ready = 1'b1;
        flush0 = 1'b0; m0_ready = 1'b1;
        repeat (3) step();
        check_eq("rst_fifo_rd", 35'(fifo_rd), 35'd0);
        check_eq("rst_m_valid", 35'(m_valid), 35'd0);
        check_eq("rst_m_data",  35'(m_data), 35'd0);
        check_eq("rst_m_bytes", 35'(m_bytes), 35'd0);
        check_eq("rst_state",   35'(state_dbg), 35'd0);
        reset = 1'b0;
        step();

        // Full word: 4 reads, never back-to-back.
        base_rd = rd_total; base_b2b = b2b; base_w = words;
        exp_q.push_back({3'd4, 32'h44332211});
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words("t1_words", base_w + 1);
        check_eq("t1_rd_pulses", 35'(rd_total - base_rd), 35'd4);
        check_eq("t1_back2back", 35'(b2b - base_b2b), 35'd0);

        // Timeout emit of a 2-byte partial. The capture cycle follows the read
        // cycle; m_valid appears in cycle 17 counted from the capture edge.
        base_w = words;
        exp_q.push_back({3'd2, 32'h00000B0A});
        push(8'h0A); push(8'h0B);
        wait_words("t2_words", base_w + 1);
        check_eq("t2_latency", 35'(valid_rise_cyc - (last_rd_cyc + 1)), 35'd17);

        // Flush of a 3-byte partial: valid the cycle after flush is sampled.
        base_rd = rd_total; base_w = words;
        exp_q.push_back({3'd3, 32'h00030201});
        push(8'h01); push(8'h02); push(8'h03);
        wait_rd("t3_rd", base_rd + 3);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t3_valid", 35'(m_valid), 35'd1);
        check_eq("t3_word", {m_bytes, m_data}, {3'd3, 32'h00030201});
        repeat (3) step();
        // Flush with nothing buffered is ignored.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("t3_empty_flush", 35'(m_valid), 35'd0);
        repeat (3) step();
        check_eq("t3_empty_flush_late", 35'(m_valid), 35'd0);
        check_eq("t3_words", 35'(words), 35'(base_w + 1));

        // Backpressure: 64 bytes, stalled consumer, then 16 words at 9 cycles each.
        m_ready = 1'b0;
        base_w = words;
        for (int i = 0; i < 16; i++)
            exp_q.push_back({3'd4, 8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        for (int i = 0; i < 64; i++) push(8'(i));
        for (int i = 0; i < 50; i++) begin
            check_eq("t4_hold_word", {m_valid, m_data}, {3'b001, 32'h03020100});
            check_eq("t4_no_rd", 35'(fifo_rd), 35'd0);
            step();
        end
        hs_cyc.delete();
        m_ready = 1'b1;
        wait_words("t4_words", base_w + 16);
        check_eq("t4_hs_count", 35'(hs_cyc.size()), 35'd16);
        if (hs_cyc.size() >= 16)
            check_eq("t4_rate", 35'(hs_cyc[15] - hs_cyc[0]), 35'd135);
        step();
        check_eq("t4_fifo_drained", 35'(fifo_cnt), 35'd0);

        // Reset during capture of the third byte discards the partial word.
        base_rd = rd_total;
        push(8'h55); push(8'h66); push(8'h77);
        wait_rd("t5_rd", base_rd + 3);
        reset = 1'b1;
        step();
        check_eq("t5_m_valid", 35'(m_valid), 35'd0);
        check_eq("t5_m_data",  35'(m_data), 35'd0);
        check_eq("t5_m_bytes", 35'(m_bytes), 35'd0);
        check_eq("t5_fifo_rd", 35'(fifo_rd), 35'd0);
        check_eq("t5_state",   35'(state_dbg), 35'd0);
        reset = 1'b0;
        base_w = words;
        exp_q.push_back({3'd4, 32'hDDCCBBAA});
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        wait_words("t5_words", base_w + 1);

        // Slow producer: one byte every 5 cycles, only full words expected.
        base_w = words;
        exp_q.push_back({3'd4, 32'h14131211});
        exp_q.push_back({3'd4, 32'h18171615});
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h11 + i));
            repeat (4) step();
        end
        repeat (30) step();
        check_eq("t6_words", 35'(words), 35'(base_w + 2));

        // TIMEOUT=0 instance: partial waits forever until flushed.
        push0(8'h0A); push0(8'h0B);
        repeat (60) step();
        check_eq("t7_no_timeout", 35'(m0_seen), 35'd0);
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        check_eq("t7_flush_valid", 35'(m0_valid), 35'd1);
        check_eq("t7_flush_word", {m0_bytes, m0_data}, {3'd2, 32'h00000B0A});
        repeat (3) step();

        check_eq("exp_q_drained", 35'(exp_q.size()), 35'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
